param_updown_counter: RTL
=========================

// Module: param_updown_counter
// PURPOSE
//   Parametrised synchronous up/down counter that succeeds the fixed 3-bit enable counter.
//   - Programmable width and terminal value; load input; direction control.
//   - Registered wrap pulse, plus a saturating wrap-event tally.
//   - Used for board-level timing, LED sequencing and event counting.
//   - q feeds display/decode logic directly.
// PARAMETERS
//   WIDTH      3            counter width in bits (1..16)
//   MAX_VAL    2**WIDTH-1   terminal value; count range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
//   RST_VAL    0            value loaded into q on reset (must be <= MAX_VAL)
//   WRAP_W     8            width of wrap_cnt tally
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        synchronous reset, active-high
//   enable     in   1        count enable; q holds when low
//   up_dn      in   1        1 = count up, 0 = count down
//   load       in   1        synchronous parallel load strobe
//   load_val   in   WIDTH    value applied on load
//   q          out  WIDTH    current count (registered)
//   tc         out  1        terminal count: q==MAX_VAL (up) / q==0 (down); combinational from q, up_dn
//   wrap       out  1        registered one-cycle pulse, cycle after a boundary event
//   wrap_cnt   out  WRAP_W   number of boundary events since reset, saturates at all-ones
// BEHAVIOUR
//   Interface
//   - One clock: clk.
//   - Reset is synchronous and active-high on rst.
//   Reset
//   - On rst=1 at a clk edge: q=RST_VAL, wrap=0, wrap_cnt=0.
//   - rst has priority over every other input, including mid-count and mid-load.
//   Per-edge priority (rst=0)
//   - Loading: load=1 -> q = (load_val > MAX_VAL) ? MAX_VAL : load_val; wrap=0.
//     - load overrides enable.
//   - Counting: enable=1, load=0 -> step q by one in direction up_dn.
//     - up:   q==MAX_VAL -> q=0, boundary event.
//     - down: q==0 -> q=MAX_VAL, boundary event.
//   - Holding: enable=0, load=0 -> q holds; wrap=0.
//   - Latency: q reflects the step/load one clk after the sampling edge.
//   Boundary event (registered)
//   - wrap=1 for exactly one cycle; otherwise wrap=0.
//   - wrap_cnt increments by 1, holding at 2**WRAP_W-1 (no rollover).
//   - Back-to-back events (e.g. MAX_VAL=0) give wrap high on consecutive cycles.
//   Direction and tc
//   - up_dn may change any cycle; it takes effect at the next edge.
//     - No extra state.
//     - No hysteresis.
//   - tc is valid whenever rst=0.
//     - Independent of enable.
//     - Used by the parent for cascading.
//   Width rules
//   - All compares are unsigned at WIDTH bits.
//   - MAX_VAL < 2**WIDTH-1 gives a mod-(MAX_VAL+1) counter.
// CONFIGURATION
//   `define CNT_SATURATE_EN
//   - Defined: the counter saturates instead of wrapping.
//     - up at MAX_VAL holds MAX_VAL.
//     - down at 0 holds 0.
//     - Each enabled cycle blocked at a bound counts as a boundary event: wrap pulse, wrap_cnt++.
//     - tc unchanged.
//   - Not defined (default): modulo wrap as in BEHAVIOUR.
// TESTING (WIDTH=3, MAX_VAL=7, RST_VAL=0 unless noted)
//   1. rst=1 for 2 clk, then enable=1, up_dn=1 for 10 clk
//      -> q 0..7,0,1; wrap high one cycle after q 7->0; wrap_cnt=1.
//   2. q=2, up_dn=0, enable=1 for 4 clk
//      -> q 1,0,7,6; tc=1 while q==0; wrap pulses once; wrap_cnt increments.
//   3. load=1, load_val=5 with enable=1 -> q=5 next cycle (load wins).
//      With MAX_VAL=5, load_val=7 -> q=5 (clamped).
//   4. enable=0 for 20 clk at q=3 -> q stays 3, wrap=0.
//      Then rst=1 while enable=1, load=1 -> q=0, wrap_cnt=0 next cycle.
//   5. MAX_VAL=4 counting up -> q 0..4,0; tc=1 at q=4.
//      WRAP_W=2 with 5 wraps -> wrap_cnt holds at 3.
//   6. With CNT_SATURATE_EN, up from 6 for 3 clk
//      -> q 7,7,7; wrap pulses on the two blocked cycles; wrap_cnt=2.

Source files
------------

// File: rtl/param_updown_counter.sv
// Purpose  : parametrised synchronous up/down counter with load, terminal count,
//            registered wrap pulse and a saturating wrap-event tally.
// Latency  : q, wrap and wrap_cnt update one clk after the sampling edge; tc is
//            combinational from q and up_dn.
// Backpress: none; every input is sampled on every rising clk edge.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active-high, highest priority
//   enable    in   1       count enable; q holds when low
//   up_dn     in   1       1 = count up, 0 = count down
//   load      in   1       parallel load strobe (overrides enable)
//   load_val  in   WIDTH   load value, clamped to MAX_VAL
//   q         out  WIDTH   current count
//   tc        out  1       q==MAX_VAL when counting up, q==0 when counting down
//   wrap      out  1       one-cycle pulse following a boundary event
//   wrap_cnt  out  WRAP_W  boundary events since reset, saturates at all-ones
//
// Build option
//   CNT_SATURATE_EN : when defined, the count stops at the bounds instead of
//                     wrapping; each enabled cycle blocked at a bound is still a
//                     boundary event.

module param_updown_counter #(
   parameter int WIDTH   = 3,
   parameter int MAX_VAL = (1 << WIDTH) - 1,
   parameter int RST_VAL = 0,
   parameter int WRAP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              up_dn,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  q,
   output logic              tc,
   output logic              wrap,
   output logic [WRAP_W-1:0] wrap_cnt
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] q_nxt;
   logic             evt;

   assign at_top = (q == MAX_Q);
   assign at_bot = (q == '0);

   // Cascade output: valid regardless of enable so a parent can chain stages.
   assign tc = up_dn ? at_top : at_bot;

   // Next count and boundary-event detection. load beats enable; a load never
   // produces a boundary event even when it lands on a bound.
   always_comb begin
      q_nxt = q;
      evt   = 1'b0;
      if (load) begin
         q_nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
      end else if (enable) begin
         if (up_dn) begin
            if (at_top) begin
               evt = 1'b1;
`ifdef CNT_SATURATE_EN
               q_nxt = MAX_Q;
`else
               q_nxt = '0;
`endif
            end else begin
               q_nxt = q + WIDTH'(1);
            end
         end else begin
            if (at_bot) begin
               evt = 1'b1;
`ifdef CNT_SATURATE_EN
               q_nxt = '0;
`else
               q_nxt = MAX_Q;
`endif
            end else begin
               q_nxt = q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= RST_Q;
         wrap     <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         q    <= q_nxt;
         wrap <= evt;
         // Tally sticks at all-ones rather than rolling back to zero.
         if (evt && !(&wrap_cnt)) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
         end
      end
   end

endmodule
